// File: rtl/pipe_hazard_ctrl.sv
// Purpose: hazard detection and forwarding control for a 5-stage in-order pipeline.
//          It keeps shadow EX/MEM/WB copies of each instruction's register usage.
// Latency: every control output is combinational from shadow state and inputs;
//          the perf counters update on the clock edge after the event.
// Backpressure: mem_ready low on a MEM access freezes the whole pipeline. During a
//          freeze the shadow stages hold and stall/flush requests are held off.
//
// Ports:
//   CLK, RESET_N                      clock, asynchronous active-low reset
//   id_*                              instruction currently in ID (sources, dest, control)
//   ex_branch_taken                   EX resolved a taken branch/jump
//   mem_ready                         data memory completes its access this cycle
//   stall_pc, stall_ifid              hold PC and IF/ID (load-use interlock)
//   flush_ifid, flush_idex            squash IF/ID and ID/EX on the next edge
//   freeze_all                        hold every pipeline register
//   fwd_a, fwd_b                      EX operand select: 00 regbank, 01 MEM/WB, 10 EX/MEM
//   id_byp_a, id_byp_b                ID register read takes WB write data
//   perf_stalls, perf_flushes         saturating event counters
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int FORWARDING = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  id_memwrite,
    input  logic                  ex_branch_taken,
    input  logic                  mem_ready,
    output logic                  stall_pc,
    output logic                  stall_ifid,
    output logic                  flush_ifid,
    output logic                  flush_idex,
    output logic                  freeze_all,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  id_byp_a,
    output logic                  id_byp_b,
    output logic [CNT_W-1:0]      perf_stalls,
    output logic [CNT_W-1:0]      perf_flushes
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic                  use1;
        logic                  use2;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regwrite;
        logic                  memread;
        logic                  memop;
    } ex_stage_t;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regwrite;
        logic                  memread;
        logic                  memop;
    } mem_stage_t;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regwrite;
    } wb_stage_t;

    localparam bit FWD_EN = (FORWARDING != 0);

    ex_stage_t  ex_q;
    mem_stage_t mem_q;
    wb_stage_t  wb_q;

    // A stage produces src when it is a live register write to a non-zero index.
    // x0 is hardwired, so it never creates a dependency.
    function automatic logic writes_reg(
        input logic                  vld,
        input logic                  rw,
        input logic [REG_ADDR_W-1:0] rd,
        input logic [REG_ADDR_W-1:0] src
    );
        return vld & rw & (rd != '0) & (rd == src);
    endfunction

    logic       mem_wait;
    logic       ex_ld_hit;
    logic       any_hit1;
    logic       any_hit2;
    logic       load_use;
    logic       stall_evt;
    logic       flush_evt;
    logic [1:0] fwd_a_raw;
    logic [1:0] fwd_b_raw;

    assign mem_wait = mem_q.valid & mem_q.memop & ~mem_ready;

    // With forwarding, only a load still in EX cannot be bypassed in time.
    assign ex_ld_hit = ex_q.valid & ex_q.memread & (ex_q.rd != '0) &
                       ((id_use_rs1 & (ex_q.rd == id_rs1)) |
                        (id_use_rs2 & (ex_q.rd == id_rs2)));

    // Without forwarding, any in-flight producer blocks ID until it has left WB.
    assign any_hit1 = writes_reg(ex_q.valid,  ex_q.regwrite,  ex_q.rd,  id_rs1) |
                      writes_reg(mem_q.valid, mem_q.regwrite, mem_q.rd, id_rs1) |
                      writes_reg(wb_q.valid,  wb_q.regwrite,  wb_q.rd,  id_rs1);
    assign any_hit2 = writes_reg(ex_q.valid,  ex_q.regwrite,  ex_q.rd,  id_rs2) |
                      writes_reg(mem_q.valid, mem_q.regwrite, mem_q.rd, id_rs2) |
                      writes_reg(wb_q.valid,  wb_q.regwrite,  wb_q.rd,  id_rs2);

    assign load_use = FWD_EN ? ex_ld_hit
                             : ((id_use_rs1 & any_hit1) | (id_use_rs2 & any_hit2));

    // EX/MEM is younger than MEM/WB, so it takes priority.
    always_comb begin
        fwd_a_raw = 2'b00;
        if (ex_q.use1 && writes_reg(mem_q.valid, mem_q.regwrite, mem_q.rd, ex_q.rs1))
            fwd_a_raw = 2'b10;
        else if (ex_q.use1 && writes_reg(wb_q.valid, wb_q.regwrite, wb_q.rd, ex_q.rs1))
            fwd_a_raw = 2'b01;
    end

    always_comb begin
        fwd_b_raw = 2'b00;
        if (ex_q.use2 && writes_reg(mem_q.valid, mem_q.regwrite, mem_q.rd, ex_q.rs2))
            fwd_b_raw = 2'b10;
        else if (ex_q.use2 && writes_reg(wb_q.valid, wb_q.regwrite, wb_q.rd, ex_q.rs2))
            fwd_b_raw = 2'b01;
    end

    // Outputs are gated by RESET_N so that an input such as ex_branch_taken
    // cannot leak a request out while the block is held in reset.
    assign freeze_all = RESET_N & mem_wait;
    assign flush_ifid = RESET_N & ~mem_wait & ex_branch_taken;
    assign flush_idex = RESET_N & ~mem_wait & ex_branch_taken;
    // A taken branch squashes the ID instruction, so its interlock is moot.
    assign stall_pc   = RESET_N & ~mem_wait & ~ex_branch_taken & load_use;
    assign stall_ifid = RESET_N & ~mem_wait & ~ex_branch_taken & load_use;

    assign fwd_a    = (FWD_EN && RESET_N) ? fwd_a_raw : 2'b00;
    assign fwd_b    = (FWD_EN && RESET_N) ? fwd_b_raw : 2'b00;
    assign id_byp_a = FWD_EN & RESET_N & id_use_rs1 &
                      writes_reg(wb_q.valid, wb_q.regwrite, wb_q.rd, id_rs1);
    assign id_byp_b = FWD_EN & RESET_N & id_use_rs2 &
                      writes_reg(wb_q.valid, wb_q.regwrite, wb_q.rd, id_rs2);

    // A stall cycle is one that actually holds the front end. A load-use that
    // a concurrent taken branch overrides costs nothing and is not counted.
    assign stall_evt = mem_wait | (load_use & ~ex_branch_taken);
    assign flush_evt = ~mem_wait & ex_branch_taken;

    // The MEM-stage load flag rides along for debug visibility. The wait logic
    // keys on memop (load or store), so nothing here consumes it.
    logic unused_mem_memread;
    assign unused_mem_memread = mem_q.memread;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!mem_wait) begin
            wb_q.valid     <= mem_q.valid;
            wb_q.rd        <= mem_q.rd;
            wb_q.regwrite  <= mem_q.regwrite;

            mem_q.valid    <= ex_q.valid;
            mem_q.rd       <= ex_q.rd;
            mem_q.regwrite <= ex_q.regwrite;
            mem_q.memread  <= ex_q.memread;
            mem_q.memop    <= ex_q.memop;

            // A bubble keeps the ID fields but is never valid, so it matches nothing.
            ex_q.valid     <= id_valid & ~load_use & ~ex_branch_taken;
            ex_q.rs1       <= id_rs1;
            ex_q.rs2       <= id_rs2;
            ex_q.use1      <= id_use_rs1;
            ex_q.use2      <= id_use_rs2;
            ex_q.rd        <= id_rd;
            ex_q.regwrite  <= id_regwrite;
            ex_q.memread   <= id_memread;
            ex_q.memop     <= id_memread | id_memwrite;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            perf_stalls  <= '0;
            perf_flushes <= '0;
        end else begin
            if (stall_evt && (perf_stalls != '1))
                perf_stalls <= perf_stalls + CNT_W'(1);
            if (flush_evt && (perf_flushes != '1))
                perf_flushes <= perf_flushes + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Purpose: self-checking bench for pipe_hazard_ctrl (default, no-forwarding, 2-bit counters).
// Latency: expectations queued per cycle are compared at the falling edge of that cycle.
// Backpressure: the bench models memory wait by driving mem_ready low.
module tb_pipe_hazard_ctrl;

    localparam int AW = 5;

    localparam int S_STALL_PC   = 0;
    localparam int S_STALL_IFID = 1;
    localparam int S_FLUSH_IFID = 2;
    localparam int S_FLUSH_IDEX = 3;
    localparam int S_FREEZE     = 4;
    localparam int S_FWD_A      = 5;
    localparam int S_FWD_B      = 6;
    localparam int S_BYP_A      = 7;
    localparam int S_BYP_B      = 8;
    localparam int S_PSTALL     = 9;
    localparam int S_PFLUSH     = 10;
    localparam int S_N_STALL    = 11;
    localparam int S_N_FWD_A    = 12;
    localparam int S_N_FWD_B    = 13;
    localparam int S_N_BYP_A    = 14;
    localparam int S_S_PSTALL   = 15;
    localparam int S_S_PFLUSH   = 16;
    localparam int S_N_PSTALL   = 17;
    localparam int N_SEL        = 18;

    logic          CLK = 1'b0;
    logic          RESET_N;
    logic          id_valid;
    logic [AW-1:0] id_rs1, id_rs2, id_rd;
    logic          id_use_rs1, id_use_rs2;
    logic          id_regwrite, id_memread, id_memwrite;
    logic          ex_branch_taken;
    logic          mem_ready;

    logic        d_stall_pc, d_stall_ifid, d_flush_ifid, d_flush_idex, d_freeze;
    logic [1:0]  d_fwd_a, d_fwd_b;
    logic        d_byp_a, d_byp_b;
    logic [15:0] d_pstall, d_pflush;

    logic        n_stall_pc, n_stall_ifid, n_flush_ifid, n_flush_idex, n_freeze;
    logic [1:0]  n_fwd_a, n_fwd_b;
    logic        n_byp_a, n_byp_b;
    logic [15:0] n_pstall, n_pflush;

    logic        s_stall_pc, s_stall_ifid, s_flush_ifid, s_flush_idex, s_freeze;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic        s_byp_a, s_byp_b;
    logic [1:0]  s_pstall, s_pflush;

    always #5 CLK = ~CLK;

    pipe_hazard_ctrl #(.REG_ADDR_W(AW), .FORWARDING(1), .CNT_W(16)) u_dut (
        .CLK(CLK), .RESET_N(RESET_N), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .ex_branch_taken(ex_branch_taken), .mem_ready(mem_ready),
        .stall_pc(d_stall_pc), .stall_ifid(d_stall_ifid), .flush_ifid(d_flush_ifid),
        .flush_idex(d_flush_idex), .freeze_all(d_freeze), .fwd_a(d_fwd_a), .fwd_b(d_fwd_b),
        .id_byp_a(d_byp_a), .id_byp_b(d_byp_b), .perf_stalls(d_pstall), .perf_flushes(d_pflush)
    );

    pipe_hazard_ctrl #(.REG_ADDR_W(AW), .FORWARDING(0), .CNT_W(16)) u_nofwd (
        .CLK(CLK), .RESET_N(RESET_N), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .ex_branch_taken(ex_branch_taken), .mem_ready(mem_ready),
        .stall_pc(n_stall_pc), .stall_ifid(n_stall_ifid), .flush_ifid(n_flush_ifid),
        .flush_idex(n_flush_idex), .freeze_all(n_freeze), .fwd_a(n_fwd_a), .fwd_b(n_fwd_b),
        .id_byp_a(n_byp_a), .id_byp_b(n_byp_b), .perf_stalls(n_pstall), .perf_flushes(n_pflush)
    );

    pipe_hazard_ctrl #(.REG_ADDR_W(AW), .FORWARDING(1), .CNT_W(2)) u_sat (
        .CLK(CLK), .RESET_N(RESET_N), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .ex_branch_taken(ex_branch_taken), .mem_ready(mem_ready),
        .stall_pc(s_stall_pc), .stall_ifid(s_stall_ifid), .flush_ifid(s_flush_ifid),
        .flush_idex(s_flush_idex), .freeze_all(s_freeze), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
        .id_byp_a(s_byp_a), .id_byp_b(s_byp_b), .perf_stalls(s_pstall), .perf_flushes(s_pflush)
    );

    // Scoreboard: parallel queues of tag / observed-signal selector / expected value.
    string       tag_q[$];
    int          sel_q[$];
    logic [31:0] val_q[$];

    int vectors     = 0;
    int miscompares = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        if (obs !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_STALL_PC:   return 32'(d_stall_pc);
            S_STALL_IFID: return 32'(d_stall_ifid);
            S_FLUSH_IFID: return 32'(d_flush_ifid);
            S_FLUSH_IDEX: return 32'(d_flush_idex);
            S_FREEZE:     return 32'(d_freeze);
            S_FWD_A:      return 32'(d_fwd_a);
            S_FWD_B:      return 32'(d_fwd_b);
            S_BYP_A:      return 32'(d_byp_a);
            S_BYP_B:      return 32'(d_byp_b);
            S_PSTALL:     return 32'(d_pstall);
            S_PFLUSH:     return 32'(d_pflush);
            S_N_STALL:    return 32'(n_stall_pc);
            S_N_FWD_A:    return 32'(n_fwd_a);
            S_N_FWD_B:    return 32'(n_fwd_b);
            S_N_BYP_A:    return 32'(n_byp_a);
            S_S_PSTALL:   return 32'(s_pstall);
            S_S_PFLUSH:   return 32'(s_pflush);
            S_N_PSTALL:   return 32'(n_pstall);
            default:      return 32'hdead_beef;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] v);
        tag_q.push_back(tag);
        sel_q.push_back(sel);
        val_q.push_back(v);
    endtask

    task automatic drain();
        while (sel_q.size() > 0) begin
            string       t;
            int          s;
            logic [31:0] v;
            t = tag_q.pop_front();
            s = sel_q.pop_front();
            v = val_q.pop_front();
            check_val(t, observe(s), v);
        end
    endtask

    task automatic expect_all_zero(input string pfx);
        for (int i = 0; i < N_SEL; i++)
            push($sformatf("%s sel%0d", pfx, i), i, 32'd0);
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen on the falling edge.
    task automatic cycle();
        @(negedge CLK);
        drain();
        @(posedge CLK);
        #1;
    endtask

    task automatic id_set(input logic v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                          input logic u1, input logic u2, input logic [AW-1:0] rd,
                          input logic rw, input logic mr, input logic mw);
        id_valid = v;  id_rs1 = rs1; id_rs2 = rs2;
        id_use_rs1 = u1; id_use_rs2 = u2; id_rd = rd;
        id_regwrite = rw; id_memread = mr; id_memwrite = mw;
    endtask

    task automatic id_nop();
        id_set(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        id_nop();
        ex_branch_taken = 1'b0;
        mem_ready = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        // Reset state, with a branch request asserted that must not leak out.
        RESET_N = 1'b0;
        id_nop();
        mem_ready = 1'b1;
        ex_branch_taken = 1'b1;
        #2;
        expect_all_zero("rst");
        drain();
        ex_branch_taken = 1'b0;
        do_reset();

        // lw x5 then add x6,x5,x7: one stall, then MEM/WB forward to the add.
        id_set(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1, 0);
        push("A0 stall_pc", S_STALL_PC, 0);
        cycle();
        id_set(1, 5'd5, 5'd7, 1, 1, 5'd6, 1, 0, 0);
        push("A1 stall_pc", S_STALL_PC, 1);
        push("A1 stall_ifid", S_STALL_IFID, 1);
        push("A1 flush_idex", S_FLUSH_IDEX, 0);
        push("A1 fwd_a", S_FWD_A, 0);
        cycle();
        push("A2 stall_pc", S_STALL_PC, 0);
        push("A2 perf_stalls", S_PSTALL, 1);
        cycle();
        id_set(1, 5'd5, 5'd0, 1, 0, 5'd9, 1, 0, 0);
        push("A3 fwd_a", S_FWD_A, 1);
        push("A3 fwd_b", S_FWD_B, 0);
        push("A3 id_byp_a", S_BYP_A, 1);
        push("A3 id_byp_b", S_BYP_B, 0);
        push("A3 stall_pc", S_STALL_PC, 0);
        push("A3 perf_stalls", S_PSTALL, 1);
        cycle();

        // add x3 in MEM and WB, reader in EX -> EX/MEM wins; with MEM empty -> MEM/WB.
        do_reset();
        id_set(1, 5'd0, 5'd0, 0, 0, 5'd3, 1, 0, 0);
        cycle();
        cycle();
        id_set(1, 5'd3, 5'd3, 1, 1, 5'd10, 1, 0, 0);
        push("B2 stall_pc", S_STALL_PC, 0);
        cycle();
        id_set(1, 5'd0, 5'd0, 0, 0, 5'd3, 1, 0, 0);
        push("B3 fwd_a", S_FWD_A, 2);
        push("B3 fwd_b", S_FWD_B, 2);
        cycle();
        id_nop();
        cycle();
        id_set(1, 5'd3, 5'd0, 1, 0, 5'd11, 1, 0, 0);
        cycle();
        id_nop();
        push("B6 fwd_a", S_FWD_A, 1);
        push("B6 fwd_b", S_FWD_B, 0);
        cycle();

        // Taken branch with a concurrent load-use: flush wins, no stall counted.
        do_reset();
        id_set(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1, 0);
        cycle();
        id_set(1, 5'd5, 5'd7, 1, 1, 5'd6, 1, 0, 0);
        ex_branch_taken = 1'b1;
        push("C1 flush_ifid", S_FLUSH_IFID, 1);
        push("C1 flush_idex", S_FLUSH_IDEX, 1);
        push("C1 stall_pc", S_STALL_PC, 0);
        push("C1 stall_ifid", S_STALL_IFID, 0);
        cycle();
        ex_branch_taken = 1'b0;
        id_nop();
        push("C2 perf_flushes", S_PFLUSH, 1);
        push("C2 perf_stalls", S_PSTALL, 0);
        push("C2 stall_pc", S_STALL_PC, 0);
        cycle();

        // sw in MEM waits 3 cycles; the pending branch flush is held off until release.
        do_reset();
        id_set(1, 5'd1, 5'd2, 1, 1, 5'd0, 0, 0, 1);
        cycle();
        id_nop();
        cycle();
        for (int k = 0; k < 3; k++) begin
            mem_ready = 1'b0;
            ex_branch_taken = 1'b1;
            push($sformatf("D%0d freeze_all", k), S_FREEZE, 1);
            push($sformatf("D%0d flush_ifid", k), S_FLUSH_IFID, 0);
            push($sformatf("D%0d flush_idex", k), S_FLUSH_IDEX, 0);
            push($sformatf("D%0d stall_pc", k), S_STALL_PC, 0);
            push($sformatf("D%0d perf_stalls", k), S_PSTALL, 32'(k));
            push($sformatf("D%0d perf_flushes", k), S_PFLUSH, 0);
            cycle();
        end
        mem_ready = 1'b1;
        push("D3 freeze_all", S_FREEZE, 0);
        push("D3 flush_ifid", S_FLUSH_IFID, 1);
        push("D3 flush_idex", S_FLUSH_IDEX, 1);
        push("D3 perf_stalls", S_PSTALL, 3);
        cycle();
        ex_branch_taken = 1'b0;
        push("D4 perf_flushes", S_PFLUSH, 1);
        push("D4 perf_stalls", S_PSTALL, 3);
        cycle();

        // No forwarding: add x4 then add x8,x4,x4 -> 3 stalls; x0 never stalls.
        do_reset();
        id_set(1, 5'd0, 5'd0, 0, 0, 5'd4, 1, 0, 0);
        push("E0 nofwd stall_pc", S_N_STALL, 0);
        cycle();
        id_set(1, 5'd4, 5'd4, 1, 1, 5'd8, 1, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            push($sformatf("E%0d nofwd stall_pc", k), S_N_STALL, 1);
            push($sformatf("E%0d nofwd fwd_a", k), S_N_FWD_A, 0);
            push($sformatf("E%0d nofwd fwd_b", k), S_N_FWD_B, 0);
            push($sformatf("E%0d nofwd id_byp_a", k), S_N_BYP_A, 0);
            cycle();
        end
        push("E4 nofwd stall_pc", S_N_STALL, 0);
        push("E4 nofwd perf_stalls", S_N_PSTALL, 3);
        cycle();
        id_set(1, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 0);
        push("E5 nofwd fwd_a", S_N_FWD_A, 0);
        push("E5 nofwd fwd_b", S_N_FWD_B, 0);
        cycle();
        id_set(1, 5'd0, 5'd0, 1, 1, 5'd12, 1, 0, 0);
        push("E6 nofwd x0 stall_pc", S_N_STALL, 0);
        cycle();
        push("E7 nofwd x0 stall_pc", S_N_STALL, 0);
        cycle();

        // Five load-use events: the 2-bit counter saturates at 3.
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            id_set(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1, 0);
            cycle();
            id_set(1, 5'd5, 5'd7, 1, 1, 5'd6, 1, 0, 0);
            push($sformatf("F%0d stall_pc", k), S_STALL_PC, 1);
            cycle();
            push($sformatf("F%0d sat perf_stalls", k), S_S_PSTALL, (k > 3) ? 32'd3 : 32'(k));
            push($sformatf("F%0d perf_stalls", k), S_PSTALL, 32'(k));
            cycle();
        end

        // Reset asserted in the middle of a stall: outputs drop at once, no hazard after.
        id_set(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1, 0);
        cycle();
        id_set(1, 5'd5, 5'd7, 1, 1, 5'd6, 1, 0, 0);
        push("G0 stall_pc", S_STALL_PC, 1);
        @(negedge CLK);
        drain();
        #1;
        RESET_N = 1'b0;
        ex_branch_taken = 1'b1;
        mem_ready = 1'b0;
        #1;
        expect_all_zero("G1 rst");
        drain();
        @(posedge CLK);
        #1;
        ex_branch_taken = 1'b0;
        mem_ready = 1'b1;
        RESET_N = 1'b1;
        push("G2 stall_pc", S_STALL_PC, 0);
        push("G2 stall_ifid", S_STALL_IFID, 0);
        push("G2 perf_stalls", S_PSTALL, 0);
        push("G2 sat perf_stalls", S_S_PSTALL, 0);
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
